// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache with a single-line refill FSM (IDLE/REQ/FILL/DONE).
// Optional hit/miss performance counters are built only when ICACHE_PERF_CNT_EN is defined.
module icache_ctrl #(
  parameter int LINES  = 64,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PC_address,
  input  logic              Icache_en,
  input  logic              flush,
  output logic [31:0]       instruction,
  output logic              hit,
  output logic              Istall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int WRD_W = $clog2(WORDS);
  localparam int OFF_W = WRD_W + 2;
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

  state_t           state;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0]      data [LINES][WORDS];
  logic [WRD_W-1:0] cnt;
  logic             pend;
  logic [31:0]      hold;

  logic [IDX_W-1:0] lat_idx;
  logic [TAG_W-1:0] lat_tag;
  logic [WRD_W-1:0] lat_word;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag_in;
  logic [WRD_W-1:0] word;
  logic             lookup_hit, idle_hit, idle_miss, last_beat;
  logic             unused_pc_bits;

  assign word           = PC_address[OFF_W-1:2];
  assign idx            = PC_address[OFF_W+IDX_W-1:OFF_W];
  assign tag_in         = PC_address[ADDR_W-1:OFF_W+IDX_W];
  assign unused_pc_bits = ^PC_address[1:0];

  assign lookup_hit = valid[idx] && (tags[idx] == tag_in);
  assign idle_hit   = (state == IDLE) && Icache_en && lookup_hit;
  assign idle_miss  = (state == IDLE) && Icache_en && !lookup_hit;
  assign last_beat  = (state == FILL) && mem_rvalid && (cnt == WRD_W'(WORDS - 1));

  assign hit = idle_hit;
  // Reset forces Istall low even while a miss would otherwise be presented.
  assign Istall = rst && (idle_miss || (state == REQ) || (state == FILL));

  always_comb begin
    instruction = hold;
    if (idle_hit)
      instruction = data[idx][word];
    else if (state == DONE)
      instruction = data[lat_idx][lat_word];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      valid    <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      cnt      <= '0;
      pend     <= 1'b0;
      hold     <= '0;
    end else begin
      if (idle_hit || (state == DONE))
        hold <= instruction;
      if (flush) begin
        valid <= '0;
        if (state != IDLE)
          pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (idle_miss) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= {tag_in, idx, {OFF_W{1'b0}}};
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            cnt     <= '0;
            state   <= FILL;
          end
        end
        FILL: begin
          if (mem_rvalid)
            cnt <= cnt + 1'b1;
          if (last_beat) begin
            state <= DONE;
            if (!pend && !flush)
              valid[lat_idx] <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          pend  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage and latched miss address carry no reset; validity lives in valid[].
  always_ff @(posedge clk) begin
    if (idle_miss) begin
      lat_idx  <= idx;
      lat_tag  <= tag_in;
      lat_word <= word;
    end
    if ((state == FILL) && mem_rvalid)
      data[lat_idx][cnt] <= mem_rdata;
    if (last_beat)
      tags[lat_idx] <= lat_tag;
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if (idle_hit)
        hits_q <= hits_q + 32'd1;
      if (idle_miss)
        misses_q <= misses_q + 32'd1;
    end
  end

  assign hit_cnt  = hits_q;
  assign miss_cnt = misses_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: a line-level cache model predicts every delivery,
// an autonomous memory responder serves refills, and a monitor compares each output cycle.
module tb_icache_ctrl;
  localparam int LINES  = 64;
  localparam int WORDS  = 4;
  localparam int ADDR_W = 32;
`ifdef ICACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] pc;
  logic              en;
  logic              flush, flush_drv, flush_mem;
  logic [31:0]       instruction;
  logic              hit, Istall, mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt, mem_rvalid;
  logic [31:0]       mem_rdata;
  logic [31:0]       hit_cnt, miss_cnt;

  assign flush = flush_drv | flush_mem;

  icache_ctrl #(.LINES(LINES), .WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .PC_address(pc), .Icache_en(en), .flush(flush),
    .instruction(instruction), .hit(hit), .Istall(Istall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: which memory line (by tag) each cache set currently holds.
  bit          mvld [LINES];
  logic [31:0] mtag [LINES];
  int unsigned mhits, mmiss;
  logic [31:0] mem_ovr [logic [31:0]];

  typedef struct { logic [31:0] instr; logic h; } exp_t;
  exp_t sbq [$];

  logic [31:0] exp_line;
  int          flush_on_beat = -1;
  int          gnt_delay = -1;
  bit          mem_auto = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < LINES; i++) mvld[i] = 1'b0;
  endfunction

  // Memory responder: grants after a delay (with junk rvalid meanwhile), then streams the line.
  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; flush_mem = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_auto && rst === 1'b1 && mem_req === 1'b1) begin
        int dly;
        check("mem_addr", mem_addr, exp_line);
        dly = (gnt_delay >= 0) ? gnt_delay : int'($urandom_range(0, 3));
        repeat (dly) begin
          mem_rvalid = 1'($urandom_range(0, 1));
          mem_rdata  = $urandom;
          @(negedge clk);
          check("mem_req_held", {31'b0, mem_req}, 32'd1);
        end
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        for (int k = 0; k < WORDS; k++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(exp_line + 32'(4 * k));
          flush_mem  = (k == flush_on_beat);
          @(negedge clk);
          mem_rvalid = 1'b0;
          flush_mem  = 1'b0;
        end
        flush_on_beat = -1;
      end
    end
  end

  // Monitor: a delivery is any cycle with a fetch presented and Istall low.
  initial begin
    logic [31:0] last;
    exp_t e;
    last = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        last = '0;
      end else if (en && !Istall) begin
        if (sbq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_delivery: got instr %h, expected none", instruction);
        end else begin
          e = sbq.pop_front();
          check("instr", instruction, e.instr);
          check("hit", {31'b0, hit}, {31'b0, e.h});
          if (hit) check("mem_req_on_hit", {31'b0, mem_req}, 32'd0);
          last = e.instr;
        end
      end else begin
        check("instr_hold", instruction, last);
        check("hit_quiet", {31'b0, hit}, 32'd0);
      end
    end
  end

  // Caller is at posedge+1; returns at posedge+1 right after the delivery cycle.
  task automatic fetch(input logic [31:0] a, input bit fl_now, input int fl_beat);
    int   line, n;
    logic [31:0] t;
    bit   h;
    line = int'(a[9:4]);
    t    = a >> 10;
    h    = mvld[line] && (mtag[line] == t);
    sbq.push_back('{instr: mem_word({a[31:2], 2'b00}), h: h});
    exp_line = {a[31:4], 4'b0};
    if (h) begin
      mhits++;
      if (fl_now) model_clear();
    end else begin
      mmiss++;
      if (fl_now) model_clear();
      if (fl_beat >= 0) begin
        flush_on_beat = fl_beat;
        model_clear();
      end else begin
        mvld[line] = 1'b1;
        mtag[line] = t;
      end
    end
    pc = a; en = 1'b1; flush_drv = fl_now;
    n = 0;
    forever begin
      @(negedge clk);
      if (!Istall) break;
      n++;
      if (n > 200) begin
        $display("FAIL fetch_timeout: pc %h still stalled after %0d cycles", a, n);
        $fatal(1, "fetch did not complete");
      end
      @(posedge clk); #1;
      flush_drv = 1'b0;
    end
    @(posedge clk); #1;
    en = 1'b0; flush_drv = 1'b0;
  endtask

  task automatic idle_cycle(input bit fl);
    en = 1'b0; flush_drv = fl;
    if (fl) model_clear();
    @(posedge clk); #1;
    flush_drv = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0; pc = '0; en = 1'b0; flush_drv = 1'b0;
    mhits = 0; mmiss = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_instr", instruction, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_istall", {31'b0, Istall}, 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Cold miss on line 0 with known contents, then three hits back to back.
    mem_ovr[32'h0] = 32'h11; mem_ovr[32'h4] = 32'h22;
    mem_ovr[32'h8] = 32'h33; mem_ovr[32'hC] = 32'h44;
    gnt_delay = 3;
    fetch(32'h0, 1'b0, -1);
    gnt_delay = -1;
    fetch(32'h4, 1'b0, -1);
    fetch(32'h8, 1'b0, -1);
    fetch(32'hC, 1'b0, -1);
    check("hit_cnt_t2", hit_cnt, PERF ? 32'(mhits) : 32'd0);
    check("miss_cnt_t2", miss_cnt, PERF ? 32'(mmiss) : 32'd0);

    // Conflict eviction on index 0.
    fetch(32'h400, 1'b0, -1);
    fetch(32'h0, 1'b0, -1);

    // Flush during beat 2 of a refill: word still delivered, line left invalid.
    fetch(32'h1230, 1'b0, 2);
    fetch(32'h1230, 1'b0, -1);

    // Reset in the middle of a refill.
    idle_cycle(1'b1);
    mem_auto = 1'b0;
    pc = 32'h0; en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mem_req !== 1'b1 && n < 20);
    check("t5_mem_req", {31'b0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_0000;
    @(negedge clk); mem_rvalid = 1'b0;
    @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_0001; rst = 1'b0;
    #1;
    check("t5_req_drop", {31'b0, mem_req}, 32'd0);
    check("t5_istall_drop", {31'b0, Istall}, 32'd0);
    check("t5_hit_drop", {31'b0, hit}, 32'd0);
    @(negedge clk); mem_rvalid = 1'b0; en = 1'b0;
    @(negedge clk); rst = 1'b1;
    model_clear(); mhits = 0; mmiss = 0;
    mem_auto = 1'b1;
    @(posedge clk); #1;
    fetch(32'h0, 1'b0, -1);

    // Randomized traffic over a small address footprint to mix hits, misses and flushes.
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [31:0] a;
      r = int'($urandom_range(0, 99));
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      if (r < 4)
        idle_cycle(1'b1);
      else if (r < 10)
        idle_cycle(1'b0);
      else
        fetch(a, (r % 20) == 0, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("final_hit_cnt", hit_cnt, PERF ? 32'(mhits) : 32'd0);
    check("final_miss_cnt", miss_cnt, PERF ? 32'(mmiss) : 32'd0);
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
